// File: rtl/ngv_pkg.sv
// Shared constants and the packed LCD entry type used by the FMC capture
// front-end and the LCD write path.
package ngv_pkg;

  localparam int FMC_PIX_W = 24;
  localparam int LCD_CTL_W = 3;

  localparam int CTL_BLK = 0;
  localparam int CTL_RS  = 1;
  localparam int CTL_RST = 2;

  typedef struct packed {
    logic [LCD_CTL_W-1:0] ctl;
    logic [FMC_PIX_W-1:0] pix;
  } lcd_entry_t;

  localparam int ENTRY_W = $bits(lcd_entry_t);

  function automatic lcd_entry_t make_entry(input logic [FMC_PIX_W-1:0] pix,
                                            input logic [LCD_CTL_W-1:0] ctl);
    lcd_entry_t e;
    e.pix = pix;
    e.ctl = ctl;
    return e;
  endfunction

endpackage

// File: rtl/fmc_wr_capture_if.sv
// FMC write bus plus the downstream valid/ready entry stream.
// slave = fmc_wr_capture side, master = host/driver and LCD consumer side.
interface fmc_wr_capture_if;
  import ngv_pkg::*;

  logic                 fmc_nwe;
  logic [3:0]           fmc_ne;
  logic [FMC_PIX_W-1:0] fmc_addr;
  logic [15:0]          fmc_data;

  logic                 o_valid;
  logic                 o_ready;
  logic [FMC_PIX_W-1:0] o_pix;
  logic [LCD_CTL_W-1:0] o_ctl;

  modport slave (
    input  fmc_nwe, fmc_ne, fmc_addr, fmc_data, o_ready,
    output o_valid, o_pix, o_ctl
  );

  modport master (
    output fmc_nwe, fmc_ne, fmc_addr, fmc_data, o_ready,
    input  o_valid, o_pix, o_ctl
  );

endinterface

// File: rtl/ngv_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Pointers carry one extra wrap bit; the head output holds the last popped
// word while the FIFO is empty.
module ngv_sync_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_last;

  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
  assign o_level = r_wr_ptr - r_rd_ptr;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_dout = o_empty ? r_last : r_mem[w_rd_idx];

  // Storage array; a write into the slot being popped is safe because the
  // head is read combinationally before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

  // Read/write pointers and the held copy of the last popped word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[w_rd_idx];
      end
    end
  end

endmodule

// File: rtl/fmc_wr_capture.sv
// FMC write capture: synchronises nWE / nE[BANK] into clk, detects completed
// write cycles to the selected bank and queues {ctl, pix} entries for the
// LCD write-timing stage.
// Optional build macro: FMC_CAPTURE_STATS_EN adds wr_cnt / drop_cnt outputs.
module fmc_wr_capture
  import ngv_pkg::*;
#(
  parameter int BANK        = 0,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  fmc_wr_capture_if.slave        bus,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   ovf,
  input  logic                   ovf_clr
`ifdef FMC_CAPTURE_STATS_EN
  ,
  output logic [31:0]            wr_cnt,
  output logic [15:0]            drop_cnt
`endif
);

  logic [SYNC_STAGES-1:0] r_nwe_sync;
  logic [SYNC_STAGES-1:0] r_ne_sync;
  logic                   r_nwe_d;
  logic                   r_sel_d;
  lcd_entry_t             r_hold;
  logic                   r_ovf;

  logic                   w_nwe_s;
  logic                   w_ne_s;
  logic                   w_wr_evt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_empty;
  logic                   w_full;
  logic [ENTRY_W-1:0]     w_head_bits;
  lcd_entry_t             w_head;
  logic                   w_unused;

  assign w_nwe_s = r_nwe_sync[SYNC_STAGES-1];
  assign w_ne_s  = r_ne_sync[SYNC_STAGES-1];

  // Strobe synchronisers idle high so a reset never looks like a write edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nwe_sync <= '1;
      r_ne_sync  <= '1;
      r_nwe_d    <= 1'b1;
    end else begin
      r_nwe_sync <= {r_nwe_sync[SYNC_STAGES-2:0], bus.fmc_nwe};
      r_ne_sync  <= {r_ne_sync[SYNC_STAGES-2:0], bus.fmc_ne[BANK]};
      r_nwe_d    <= w_nwe_s;
    end
  end

  // Remember that this bank was selected during the low phase of nWE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_d <= 1'b0;
    end else if (w_wr_evt) begin
      r_sel_d <= 1'b0;
    end else if (!w_nwe_s && !w_ne_s) begin
      r_sel_d <= 1'b1;
    end
  end

  // Track the bus while the selected write is active; the bus-timing contract
  // keeps addr/data stable until after the last load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (!w_nwe_s && !w_ne_s) begin
      r_hold <= make_entry(bus.fmc_addr, bus.fmc_data[LCD_CTL_W-1:0]);
    end
  end

  assign w_wr_evt = w_nwe_s & ~r_nwe_d & r_sel_d;
  assign w_pop    = ~w_empty & bus.o_ready;
  assign w_push   = w_wr_evt & (~w_full | w_pop);
  assign w_drop   = w_wr_evt & w_full & ~w_pop;

  ngv_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_din   (r_hold),
    .i_pop   (w_pop),
    .o_dout  (w_head_bits),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (o_level)
  );

  assign w_head      = lcd_entry_t'(w_head_bits);
  assign bus.o_valid = ~w_empty;
  assign bus.o_pix   = w_head.pix;
  assign bus.o_ctl   = w_head.ctl;

  // Sticky overflow; a drop in the same cycle as the clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;

`ifdef FMC_CAPTURE_STATS_EN
  logic [31:0] r_wr_cnt;
  logic [15:0] r_drop_cnt;

  // Accepted-push and dropped-write counters; a drop coinciding with a clear
  // is counted after the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_cnt <= r_wr_cnt + 32'd1;
      if (ovf_clr) r_drop_cnt <= {15'd0, w_drop};
      else if (w_drop) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign wr_cnt   = r_wr_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

  // Data bits above the control field and the other chip selects are not used.
  assign w_unused = ^{bus.fmc_data[15:LCD_CTL_W], bus.fmc_ne};

endmodule
